// File: rtl/core_run_ctrl.sv
// Execution controller for the RV32 core: turns debounced button pulses into a
// one-cycle core clock enable with halt, single-step, free-run and run-N modes.
module core_run_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             n_valid,
    input  logic [CNT_W-1:0] n_steps,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             core_ce,
    output logic             halted,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [31:0]      retired
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_RUNN = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_RESET = 2'd0;
    localparam logic [1:0] CAUSE_USER  = 2'd1;
    localparam logic [1:0] CAUSE_COUNT = 2'd2;
    localparam logic [1:0] CAUSE_BP    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       cause_r;
    logic [1:0]       cause_nxt_s;
    logic [CNT_W-1:0] remain_r;
    logic             bp_armed_r;
    logic [31:0]      retired_r;
    logic             bp_hit_s;
    logic             ce_s;
    logic             halted_s;
    logic             load_n_s;
    logic             leave_halt_s;
    logic             unused_addr_bits_s;

    // Word-aligned compare; byte-offset bits of both addresses are don't-care.
    assign bp_hit_s           = bp_en & bp_armed_r & (pc[31:2] == bp_addr[31:2]);
    assign unused_addr_bits_s = ^{pc[1:0], bp_addr[1:0]};
    assign leave_halt_s       = (state_r == ST_HALT) && (state_nxt_s != ST_HALT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_HALT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and halt-cause selection; breakpoint outranks a user abort.
    always_comb begin
        state_nxt_s = state_r;
        cause_nxt_s = cause_r;
        load_n_s    = 1'b0;
        case (state_r)
            ST_HALT: begin
                if (run_btn) begin
                    state_nxt_s = ST_RUN;
                end else if (n_valid && (n_steps != CNT_ZERO)) begin
                    state_nxt_s = ST_RUNN;
                    load_n_s    = 1'b1;
                end else if (step_btn) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_STEP: begin
                state_nxt_s = ST_HALT;
                cause_nxt_s = CAUSE_USER;
            end
            ST_RUN: begin
                if (bp_hit_s) begin
                    state_nxt_s = ST_HALT;
                    cause_nxt_s = CAUSE_BP;
                end else if (run_btn) begin
                    state_nxt_s = ST_HALT;
                    cause_nxt_s = CAUSE_USER;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUNN: begin
                if (bp_hit_s) begin
                    state_nxt_s = ST_HALT;
                    cause_nxt_s = CAUSE_BP;
                end else if (run_btn) begin
                    state_nxt_s = ST_HALT;
                    cause_nxt_s = CAUSE_USER;
                end else if (remain_r == CNT_ONE) begin
                    state_nxt_s = ST_HALT;
                    cause_nxt_s = CAUSE_COUNT;
                end else begin
                    state_nxt_s = ST_RUNN;
                end
            end
            default: begin
                state_nxt_s = ST_HALT;
                cause_nxt_s = CAUSE_RESET;
            end
        endcase
    end

    // Core enable is combinational so a breakpoint suppresses the matching instruction.
    always_comb begin
        ce_s     = 1'b0;
        halted_s = 1'b0;
        case (state_r)
            ST_HALT: halted_s = 1'b1;
            ST_STEP: ce_s     = 1'b1;
            ST_RUN:  ce_s     = ~bp_hit_s;
            ST_RUNN: ce_s     = ~bp_hit_s;
            default: halted_s = 1'b1;
        endcase
    end

    // Halt cause register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_r <= CAUSE_RESET;
        end else begin
            cause_r <= cause_nxt_s;
        end
    end

    // Run-N remaining count; held on a breakpoint stop until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain_r <= CNT_ZERO;
        end else if (load_n_s) begin
            remain_r <= n_steps;
        end else if ((state_r == ST_RUNN) && ce_s) begin
            remain_r <= remain_r - CNT_ONE;
        end
    end

    // Breakpoint disarmed on resume so execution can leave a PC equal to bp_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_armed_r <= 1'b0;
        end else if (leave_halt_s) begin
            bp_armed_r <= 1'b0;
        end else if (ce_s) begin
            bp_armed_r <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= 32'd0;
        end else if (ce_s) begin
            retired_r <= retired_r + 32'd1;
        end
    end

    assign core_ce    = ce_s;
    assign halted     = halted_s;
    assign state      = state_r;
    assign halt_cause = cause_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: step, run-N, breakpoint, abort, reset and wrap.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_btn = 1'b0;
    logic        run_btn = 1'b0;
    logic        n_valid = 1'b0;
    logic [15:0] n_steps = 16'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc;
    logic        core_ce;
    logic        halted;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] retired;

    int total = 0;
    int bad = 0;
    int cnt;

    core_run_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_btn(run_btn),
        .n_valid(n_valid), .n_steps(n_steps), .bp_en(bp_en), .bp_addr(bp_addr),
        .pc(pc), .core_ce(core_ce), .halted(halted), .state(state),
        .halt_cause(halt_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    // Core PC model: advances one word per enabled cycle.
    always @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else if (core_ce) pc <= pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Count core_ce over n cycles, sampling at the falling edge.
    task automatic count_ce(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (core_ce) c++;
            cyc();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_ce", {31'd0, core_ce}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_cause", {30'd0, halt_cause}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Three single steps, 5 cycles apart
        for (int k = 0; k < 3; k++) begin
            step_btn = 1'b1;
            cyc();
            step_btn = 1'b0;
            @(negedge clk);
            chk("step_ce", {31'd0, core_ce}, 32'd1);
            cyc();
            count_ce(4, cnt);
            chk("step_idle", cnt, 32'd0);
        end
        chk("step_retired", retired, 32'd3);
        chk("step_cause", {30'd0, halt_cause}, 32'd1);
        chk("step_state", {30'd0, state}, 32'd0);

        // Run-N with 10, then with 0
        do_reset();
        n_steps = 16'd10;
        n_valid = 1'b1;
        cyc();
        n_valid = 1'b0;
        count_ce(10, cnt);
        chk("runn10_ce", cnt, 32'd10);
        @(negedge clk);
        chk("runn10_halted", {31'd0, halted}, 32'd1);
        chk("runn10_cause", {30'd0, halt_cause}, 32'd2);
        chk("runn10_retired", retired, 32'd10);
        n_steps = 16'd0;
        n_valid = 1'b1;
        cyc();
        n_valid = 1'b0;
        count_ce(3, cnt);
        chk("runn0_ce", cnt, 32'd0);
        chk("runn0_state", {30'd0, state}, 32'd0);
        chk("runn0_retired", retired, 32'd10);

        // Breakpoint at 0x20 with incrementing PC, then resume past it
        do_reset();
        bp_en = 1'b1;
        bp_addr = 32'h0000_0020;
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        count_ce(10, cnt);
        chk("bp_ce", cnt, 32'd8);
        chk("bp_pc", pc, 32'h20);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_cause", {30'd0, halt_cause}, 32'd3);
        chk("bp_retired", retired, 32'd8);
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        count_ce(3, cnt);
        chk("bp_resume_ce", cnt, 32'd3);
        chk("bp_resume_pc", pc, 32'h2c);
        chk("bp_resume_state", {30'd0, state}, 32'd2);
        run_btn = 1'b1;
        @(negedge clk);
        chk("stop_pulse_ce", {31'd0, core_ce}, 32'd1);
        cyc();
        run_btn = 1'b0;
        chk("stop_retired", retired, 32'd12);
        chk("stop_cause", {30'd0, halt_cause}, 32'd1);
        bp_en = 1'b0;

        // Free run, abort after 7 cycles
        do_reset();
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        chk("abort_retired", retired, 32'd8);
        chk("abort_cause", {30'd0, halt_cause}, 32'd1);
        chk("abort_state", {30'd0, state}, 32'd0);

        // run_btn beats n_valid from HALT
        n_steps = 16'd5;
        run_btn = 1'b1;
        n_valid = 1'b1;
        cyc();
        run_btn = 1'b0;
        n_valid = 1'b0;
        chk("prio_state", {30'd0, state}, 32'd2);
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        chk("prio_stop", {30'd0, state}, 32'd0);

        // Reset during run-N of 100 at step 40
        do_reset();
        n_steps = 16'd100;
        n_valid = 1'b1;
        cyc();
        n_valid = 1'b0;
        for (int i = 0; i < 40; i++) cyc();
        chk("mid_retired", retired, 32'd40);
        rst = 1'b1;
        #1;
        chk("mid_rst_ce", {31'd0, core_ce}, 32'd0);
        chk("mid_rst_state", {30'd0, state}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_retired", retired, 32'd0);
        chk("post_rst_state", {30'd0, state}, 32'd0);

        // Retired counter wrap
        force dut.retired_r = 32'hFFFF_FFFF;
        #1;
        release dut.retired_r;
        #1;
        chk("wrap_preload", retired, 32'hFFFF_FFFF);
        step_btn = 1'b1;
        cyc();
        step_btn = 1'b0;
        cyc();
        chk("wrap_retired", retired, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Execution controller between the debounced front-panel buttons and the RV32 core. It replaces the raw button-as-clock scheme with a single system clock plus a one-cycle core clock enable. It supports halted, single-step, free-run and run-N-instructions modes, with a PC breakpoint and a retired-instruction counter. The core, register file and data memory sit on `clk` and advance only in cycles where `core_ce` is high; the PC display keeps showing `pc` while the core is halted.

## Interface
- `CNT_W`, 16: width of the run-N step count.
- `clk`  in  1  system clock; the core and seg16 share this domain.
- `rst`  in  1  asynchronous, active-high reset.
- `step_btn`  in  1  one-`clk`-wide pulse from the key debouncer: execute one instruction.
- `run_btn`  in  1  one-`clk`-wide pulse: toggle free-run / halt.
- `n_valid`  in  1  one-cycle strobe: load `n_steps` and start run-N.
- `n_steps`  in  CNT_W  number of instructions for run-N.
- `bp_en`  in  1  breakpoint enable (level).
- `bp_addr`  in  32  breakpoint PC; bits [1:0] are ignored in the compare.
- `pc`  in  32  current core PC.
- `core_ce`  out  1  core clock enable; the core retires one instruction per high cycle.
- `halted`  out  1  high when the FSM is in HALT.
- `state`  out  2  encoding: HALT=0, STEP=1, RUN=2, RUNN=3.
- `halt_cause`  out  2  encoding: 0 reset, 1 user, 2 count done, 3 breakpoint.
- `retired`  out  32  count of `core_ce` cycles; wraps modulo 2^32.

## Operation
- The FSM state, `remain` (CNT_W), `bp_armed`, `halt_cause` and `retired` are all registers.
- `bp_hit = bp_en & bp_armed & (pc[31:2] == bp_addr[31:2])`.
- `core_ce` is combinational:
  - high in STEP;
  - high in RUN or RUNN when `!bp_hit`;
  - low in HALT.
- HALT:
  - Priority when inputs coincide: `run_btn` > `n_valid` > `step_btn`.
  - `run_btn` -> RUN.
  - `n_valid` with `n_steps != 0` -> RUNN, with `remain <= n_steps`.
  - `n_valid` with `n_steps == 0` is ignored; the FSM stays in HALT.
  - `step_btn` -> STEP.
  - Every exit from HALT clears `bp_armed`.
- STEP: lasts exactly one cycle (`core_ce` = 1), then -> HALT with `halt_cause = 1`. The breakpoint never blocks a step.
- RUN:
  - `run_btn` -> HALT, cause 1.
  - `bp_hit` -> HALT, cause 3. `core_ce` is low in that cycle, so the instruction at the breakpoint is not executed.
- RUNN:
  - Each `core_ce` cycle decrements `remain`.
  - A `core_ce` cycle with `remain == 1` -> HALT, cause 2.
  - `run_btn` -> HALT, cause 1 (abort).
  - `bp_hit` -> HALT, cause 3. `remain` holds its value; it is reloaded on the next `n_valid`.
- If `bp_hit` and `run_btn` occur in the same cycle, cause 3 wins.
- `bp_armed` sets after the first `core_ce` cycle following an exit from HALT. This lets RUN or RUNN resume from a PC equal to `bp_addr` without re-halting there.
- `step_btn` and `n_valid` are ignored outside HALT.
- `retired` increments on every `core_ce` cycle.

## Timing
- Reset (async, takes effect immediately):
  - `state` = HALT, `core_ce` = 0, `halted` = 1;
  - `halt_cause` = 0, `retired` = 0, `remain` = 0, `bp_armed` = 0.
- Latency from button pulse to the first `core_ce` cycle: 1 cycle.
- STEP yields exactly one `core_ce` cycle per `step_btn` pulse.
- RUN has `core_ce` continuously high; the maximum rate is 1 instruction per `clk`.
- RUNN with value N gives exactly N consecutive `core_ce` cycles (absent a breakpoint or abort). `halted` rises in the cycle after the last one.
- Breakpoint stop: `pc` compare is combinational. `core_ce` drops in the same cycle that `pc` equals `bp_addr`; `halted` rises the next cycle.
- `run_btn` during RUN: `core_ce` stays high in the pulse cycle and is low from the next cycle on.
- Reset asserted mid-RUN or mid-RUNN: `core_ce` drops asynchronously, so no partial count is retained.
- `remain` never underflows; RUNN cannot be entered with 0.

## Test plan
- Reset, then `step_btn` ×3 pulses spaced 5 cycles apart -> `core_ce` is high for exactly 3 single cycles, each one cycle after its pulse; `retired` = 3; `halt_cause` = 1.
- `n_valid` with `n_steps` = 10 -> 10 consecutive `core_ce` cycles; then `halted` = 1, `halt_cause` = 2, `retired` = 10. A second case with `n_steps` = 0 -> no `core_ce`, state stays HALT.
- `bp_en` = 1, `bp_addr` = 0x20, `pc` model incrementing by 4 from 0, `run_btn` -> `core_ce` high for 8 cycles, low at `pc` = 0x20; `halt_cause` = 3. A further `run_btn` -> the core resumes past 0x20 without an immediate re-halt.
- RUN, then `run_btn` after 7 cycles -> `retired` = 8 (`core_ce` still high in the pulse cycle), `halt_cause` = 1. Simultaneous `run_btn` and `n_valid` from HALT -> RUN is taken.
- RUNN with `n_steps` = 100, `rst` asserted at step 40 -> `core_ce` = 0 immediately; `retired` = 0 and `state` = HALT after reset release.
- `retired` preloaded by running 2^32−1 cycles (or forced), then one step -> `retired` wraps to 0.
